// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Two requesters compete for a single register-file write port. A single
//   output entry (W_*) holds the granted write until the register file
//   consumes it. While the entry is free (empty, or draining this cycle), one
//   valid requester is granted combinationally and its write is loaded on the
//   next rising edge. This sustains one write per cycle.
//
//   Optional feature: REGFILE_ARB_ROUND_ROBIN_EN
//     defined   -> ties alternate; the winner is the requester that was not
//                  granted last.
//     undefined -> fixed priority; requester 0 always wins a tie, and no
//                  pointer register is built.
//
// Ports
//   CLK                 clock; all state updates on the rising edge
//   RESET               synchronous, active-high reset
//   I0_valid/addr/data  requester 0 write request (addr 2b, data 32b)
//   I0_ready            requester 0 accepted this cycle
//   I1_*                requester 1, same as I0_*
//   W_valid/addr/data   pending register-file write
//   W_ready             register file consumes the pending write
//   S                   index of the requester whose write is held
module regfile_write_arbiter (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        I0_valid,
  input  logic [1:0]  I0_addr,
  input  logic [31:0] I0_data,
  output logic        I0_ready,
  input  logic        I1_valid,
  input  logic [1:0]  I1_addr,
  input  logic [31:0] I1_data,
  output logic        I1_ready,
  output logic        W_valid,
  output logic [1:0]  W_addr,
  output logic [31:0] W_data,
  input  logic        W_ready,
  output logic        S
);

  logic        w_valid_q, w_valid_d;
  logic [1:0]  w_addr_q,  w_addr_d;
  logic [31:0] w_data_q,  w_data_d;
  logic        s_q,       s_d;

  logic free;
  logic gnt1;  // 1: requester 1 wins the arbitration this cycle
  logic xfer0, xfer1;

  // The entry can accept a new write if it is empty, or if it drains this cycle.
  assign free = !w_valid_q || W_ready;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  logic last_q, last_d;  // index of the requester granted most recently

  // On a tie, grant the requester that did not win last time.
  always_comb begin
    gnt1 = 1'b0;
    if (I1_valid && !I0_valid)     gnt1 = 1'b1;
    else if (I1_valid && I0_valid) gnt1 = (last_q == 1'b0);
  end

  // The pointer moves only when a transfer happens.
  always_comb begin
    last_d = last_q;
    if (xfer0)      last_d = 1'b0;
    else if (xfer1) last_d = 1'b1;
  end

  // Reset to 1, so requester 0 wins the first tie after reset.
  always_ff @(posedge CLK) begin
    if (RESET) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`else
  // Fixed priority: requester 1 wins only when it is the sole requester.
  always_comb begin
    gnt1 = I1_valid && !I0_valid;
  end
`endif

  // Readies are gated by RESET, so nothing is accepted during a reset cycle.
  // The valid terms keep ready low for an idle requester.
  assign xfer0 = !RESET && free && I0_valid && !gnt1;
  assign xfer1 = !RESET && free && I1_valid &&  gnt1;

  assign I0_ready = xfer0;
  assign I1_ready = xfer1;

  always_comb begin
    w_valid_d = w_valid_q;
    w_addr_d  = w_addr_q;
    w_data_d  = w_data_q;
    s_d       = s_q;
    if (xfer0) begin
      w_valid_d = 1'b1;
      w_addr_d  = I0_addr;
      w_data_d  = I0_data;
      s_d       = 1'b0;
    end else if (xfer1) begin
      w_valid_d = 1'b1;
      w_addr_d  = I1_addr;
      w_data_d  = I1_data;
      s_d       = 1'b1;
    end else if (w_valid_q && W_ready) begin
      // Drained with no refill. The payload is kept; only valid drops.
      w_valid_d = 1'b0;
    end
  end

  // A reset discards any pending entry.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      w_valid_q <= 1'b0;
      w_addr_q  <= 2'd0;
      w_data_q  <= 32'd0;
      s_q       <= 1'b0;
    end else begin
      w_valid_q <= w_valid_d;
      w_addr_q  <= w_addr_d;
      w_data_q  <= w_data_d;
      s_q       <= s_d;
    end
  end

  assign W_valid = w_valid_q;
  assign W_addr  = w_addr_q;
  assign W_data  = w_data_q;
  assign S       = s_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter.
// Inputs change 1ns after the rising edge. Ready outputs are sampled 1ns
// later, in the same cycle. Registered outputs are sampled 1ns after the next
// rising edge.
module tb_regfile_write_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        I0_valid, I1_valid;
  logic [1:0]  I0_addr,  I1_addr;
  logic [31:0] I0_data,  I1_data;
  logic        I0_ready, I1_ready;
  logic        W_valid;
  logic [1:0]  W_addr;
  logic [31:0] W_data;
  logic        W_ready;
  logic        S;

  int tests = 0;
  int fails = 0;

  regfile_write_arbiter dut (
    .CLK(CLK), .RESET(RESET),
    .I0_valid(I0_valid), .I0_addr(I0_addr), .I0_data(I0_data), .I0_ready(I0_ready),
    .I1_valid(I1_valid), .I1_addr(I1_addr), .I1_data(I1_data), .I1_ready(I1_ready),
    .W_valid(W_valid), .W_addr(W_addr), .W_data(W_data), .W_ready(W_ready), .S(S)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [31:0] held;
  logic        exp_g1;

  initial begin
    RESET = 1'b1; W_ready = 1'b0;
    I0_valid = 1'b1; I0_addr = 2'd1; I0_data = 32'h1111_1111;
    I1_valid = 1'b1; I1_addr = 2'd2; I1_data = 32'h2222_2222;
    tick();
    #1;
    // Both requesters are valid, but RESET blocks both readies.
    chk("rst_i0_ready", I0_ready, 0);
    chk("rst_i1_ready", I1_ready, 0);
    tick();
    chk("rst_w_valid", W_valid, 0);
    chk("rst_w_addr",  W_addr,  0);
    chk("rst_w_data",  W_data,  0);
    chk("rst_s",       S,       0);

    // Lone write from requester 0.
    RESET = 1'b0; W_ready = 1'b1;
    I0_valid = 1'b1; I0_addr = 2'd2; I0_data = 32'hDEAD_BEEF;
    I1_valid = 1'b0;
    #1;
    chk("basic_i0_ready", I0_ready, 1);
    chk("basic_i1_ready", I1_ready, 0);
    tick();
    chk("basic_w_valid", W_valid, 1);
    chk("basic_w_addr",  W_addr,  2);
    chk("basic_w_data",  W_data,  32'hDEAD_BEEF);
    chk("basic_s",       S,       0);

    // Drain with no new request: the entry empties.
    I0_valid = 1'b0;
    #1;
    chk("idle_i0_ready", I0_ready, 0);
    tick();
    chk("drain_w_valid", W_valid, 0);

    // Fresh reset, then requester 1 alone is granted at once.
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    I1_valid = 1'b1; I1_addr = 2'd1; I1_data = 32'hCAFE_0001;
    #1;
    chk("lone1_i1_ready", I1_ready, 1);
    chk("lone1_i0_ready", I0_ready, 0);
    tick();
    chk("lone1_w_data", W_data, 32'hCAFE_0001);
    chk("lone1_s",      S,      1);

    // Both valid every cycle while the entry drains each cycle.
    // Round-robin expects grants 0,1,0,1 (last grant was 1); fixed expects 0,0,0,0.
    I0_valid = 1'b1; I0_addr = 2'd0; I0_data = 32'h0000_1000;
    I1_valid = 1'b1; I1_addr = 2'd3; I1_data = 32'h0000_2000;
    W_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
`ifdef REGFILE_ARB_ROUND_ROBIN_EN
      exp_g1 = (k % 2) == 1;
`else
      exp_g1 = 1'b0;
`endif
      #1;
      chk($sformatf("tie%0d_i0_ready", k), I0_ready, !exp_g1);
      chk($sformatf("tie%0d_i1_ready", k), I1_ready, exp_g1);
      tick();
      chk($sformatf("tie%0d_s", k),      S,      exp_g1);
      chk($sformatf("tie%0d_w_data", k), W_data, exp_g1 ? 32'h0000_2000 : 32'h0000_1000);
    end
    held = exp_g1 ? 32'h0000_2000 : 32'h0000_1000;

    // Backpressure: the entry is held, and the new request waits.
    I0_valid = 1'b0;
    I1_valid = 1'b1; I1_addr = 2'd3; I1_data = 32'h1234_5678;
    W_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("stall%0d_i1_ready", k), I1_ready, 0);
      tick();
      chk($sformatf("stall%0d_w_valid", k), W_valid, 1);
      chk($sformatf("stall%0d_w_data", k),  W_data,  held);
      chk($sformatf("stall%0d_s", k),       S,       exp_g1);
    end
    W_ready = 1'b1;
    #1;
    chk("unstall_i1_ready", I1_ready, 1);
    tick();
    chk("unstall_w_data", W_data, 32'h1234_5678);
    chk("unstall_w_addr", W_addr, 3);
    chk("unstall_s",      S,      1);

    // Reset while an entry is pending.
    I1_valid = 1'b0;
    I0_valid = 1'b1; I0_addr = 2'd1; I0_data = 32'hA5A5_A5A5;
    tick();
    chk("pre_rst_w_data",  W_data,  32'hA5A5_A5A5);
    chk("pre_rst_w_valid", W_valid, 1);
    I0_valid = 1'b0; W_ready = 1'b0; RESET = 1'b1;
    I1_valid = 1'b1;
    #1;
    chk("midrst_i1_ready", I1_ready, 0);
    tick();
    chk("midrst_w_valid", W_valid, 0);
    chk("midrst_w_data",  W_data,  0);
    chk("midrst_s",       S,       0);

    // After release, requester 0 wins the first tie in either build.
    RESET = 1'b0;
    I0_valid = 1'b1; I0_data = 32'h0BAD_F00D; I0_addr = 2'd2;
    I1_valid = 1'b1; I1_data = 32'h7777_7777;
    #1;
    chk("post_rst_i0_ready", I0_ready, 1);
    chk("post_rst_i1_ready", I1_ready, 0);
    tick();
    chk("post_rst_s",      S,      0);
    chk("post_rst_w_data", W_data, 32'h0BAD_F00D);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
